// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Holds the loader FSM encoding and the image framing constants.
package boot_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_DONE,
    S_ERR
  } loader_state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses for
// one cycle after every fourth accepted byte. clear drops any partial word.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        clear,
  input  logic        byte_stb,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_p0;
  logic [23:0] asm_p0;
  logic [31:0] word_p1;
  logic        vld_p1;

  // Stage p0: byte index and assembly of the lower three bytes
  always_ff @(posedge clk) begin
    if (clear) begin
      idx_p0 <= 2'd0;
    end else if (byte_stb) begin
      idx_p0 <= idx_p0 + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_stb && (idx_p0 != 2'd3)) begin
      asm_p0 <= {byte_in, asm_p0[23:8]};
    end
  end

  // Stage p1: completed word and its one-cycle valid
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_p1  <= 1'b0;
      word_p1 <= 32'd0;
    end else begin
      vld_p1 <= 1'b0;
      if (byte_stb && (idx_p0 == 2'd3)) begin
        vld_p1  <= 1'b1;
        word_p1 <= {byte_in, asm_p0};
      end
    end
  end

  assign word       = word_p1;
  assign word_valid = vld_p1;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed program image into instruction memory
// and keeps the core in reset until the last word has been written.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int IDX_W = $clog2(DEPTH + 1);

  loader_state_t     state, state_n;
  logic              armed;
  logic [7:0]        len_lo;
  logic [15:0]       len_q;
  logic [15:0]       len_full;
  logic [IDX_W-1:0]  word_idx;
  logic [ADDR_W-1:0] addr_q;
  logic              core_q;
  logic              byte_acc;
  logic              last_word;
  logic              pk_clear;
  logic              pk_vld;
  logic [31:0]       pk_word;

  assign byte_ready = armed && ((state == S_LEN0) || (state == S_LEN1) || (state == S_DATA));
  assign byte_acc   = byte_valid && byte_ready;
  assign len_full   = {byte_data, len_lo};
  assign last_word  = (32'(word_idx) == (32'(len_q) - 32'd1));

  // Outside S_DATA the packer is held empty, so a reset mid-word drops the partial word.
  assign pk_clear = !reset || (state != S_DATA);

  byte_to_word_packer u_packer (
    .clk        (clk),
    .clear      (pk_clear),
    .byte_stb   (byte_acc),
    .byte_in    (byte_data),
    .word       (pk_word),
    .word_valid (pk_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_LEN0;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_LEN0: begin
        if (byte_acc) state_n = S_LEN1;
      end
      S_LEN1: begin
        if (byte_acc) begin
          if (len_full == 16'd0) begin
            state_n = S_DONE;
          end else if (32'(len_full) > 32'(DEPTH)) begin
            state_n = S_ERR;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_vld && last_word) state_n = S_DONE;
      end
      S_DONE:  state_n = S_DONE;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_LEN0;
    endcase
  end

  // byte_ready is held low until the first edge that sees reset released.
  always_ff @(posedge clk) begin
    if (!reset) begin
      armed    <= 1'b0;
      word_idx <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      core_q   <= 1'b0;
    end else begin
      armed  <= 1'b1;
      core_q <= (state == S_DONE);
      if (pk_vld) begin
        word_idx <= word_idx + IDX_W'(1);
        addr_q   <= addr_q + ADDR_W'(BYTES_PER_WORD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (byte_acc && (state == S_LEN0)) len_lo <= byte_data;
    if (byte_acc && (state == S_LEN1)) len_q  <= len_full;
  end

  assign imem_we    = pk_vld;
  assign imem_wdata = pk_word;
  assign imem_addr  = addr_q;
  assign core_reset = core_q;
  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0x0 and 0x100) checked every
// cycle against a byte-count model, plus literal checks on the logged writes.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        bv0, bv1;
  logic [7:0]  bd0, bd1;
  logic        rdy0, rdy1, we0, we1, core0, core1, done0, done1, err0, err1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam int DEPTH_M = 256;
  logic [31:0] base_m [2];
  initial begin
    base_m[0] = 32'h0000_0000;
    base_m[1] = 32'h0000_0100;
  end

  imem_boot_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(reset), .byte_valid(bv0), .byte_data(bd0), .byte_ready(rdy0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .core_reset(core0),
    .load_done(done0), .load_error(err0));

  imem_boot_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0100), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset), .byte_valid(bv1), .byte_data(bd1), .byte_ready(rdy1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .core_reset(core1),
    .load_done(done1), .load_error(err1));

  // Model state: everything follows from how many bytes have been accepted.
  int          m_cnt   [2];
  int          m_n     [2];
  int          m_widx  [2];
  logic        m_rdy   [2];
  logic        m_we    [2];
  logic        m_core  [2];
  logic        m_done  [2];
  logic        m_err   [2];
  logic        m_inrst [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_word  [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic       bvd;
      logic [7:0] bdd;
      logic       acc;
      int         pos;
      bvd = (d == 0) ? bv0 : bv1;
      bdd = (d == 0) ? bd0 : bd1;
      if (!reset) begin
        m_cnt[d] = 0; m_n[d] = 0; m_widx[d] = 0;
        m_rdy[d] = 1'b0; m_we[d] = 1'b0; m_core[d] = 1'b0;
        m_done[d] = 1'b0; m_err[d] = 1'b0; m_inrst[d] = 1'b1;
        m_addr[d] = base_m[d]; m_wdata[d] = 32'd0; m_word[d] = 32'd0;
      end else begin
        m_inrst[d] = 1'b0;
        acc = bvd && m_rdy[d];
        m_core[d] = m_done[d];
        if (m_we[d]) begin
          m_widx[d]++;
          if (m_widx[d] == m_n[d]) m_done[d] = 1'b1;
        end
        m_we[d] = 1'b0;
        if (acc) begin
          if (m_cnt[d] == 0) begin
            m_n[d] = int'(bdd);
          end else if (m_cnt[d] == 1) begin
            m_n[d] = m_n[d] + 256 * int'(bdd);
            if (m_n[d] == 0) m_done[d] = 1'b1;
            else if (m_n[d] > DEPTH_M) m_err[d] = 1'b1;
          end else begin
            pos = (m_cnt[d] - 2) % 4;
            m_word[d][pos*8 +: 8] = bdd;
            if (pos == 3) begin
              m_we[d]    = 1'b1;
              m_wdata[d] = m_word[d];
              m_addr[d]  = base_m[d] + 32'(4 * ((m_cnt[d] - 2) / 4));
            end
          end
          m_cnt[d]++;
        end
        m_rdy[d] = !m_done[d] && !m_err[d];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic we, input logic core,
                           input logic done, input logic err, input logic [31:0] addr,
                           input logic [31:0] wdata);
    chk($sformatf("byte_ready%0d", d), 32'(rdy),  32'(m_rdy[d]));
    chk($sformatf("imem_we%0d", d),    32'(we),   32'(m_we[d]));
    chk($sformatf("core_reset%0d", d), 32'(core), 32'(m_core[d]));
    chk($sformatf("load_done%0d", d),  32'(done), 32'(m_done[d]));
    chk($sformatf("load_error%0d", d), 32'(err),  32'(m_err[d]));
    if (m_we[d] || m_inrst[d]) begin
      chk($sformatf("imem_addr%0d", d),  addr,  m_addr[d]);
      chk($sformatf("imem_wdata%0d", d), wdata, m_wdata[d]);
    end
  endtask

  logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
  int          cyc_we0   = 0;
  int          cyc_core0 = 0;
  logic        core0_q   = 1'b0;

  always @(negedge clk) begin
    cyc++;
    check_dut(0, rdy0, we0, core0, done0, err0, addr0, wdata0);
    check_dut(1, rdy1, we1, core1, done1, err1, addr1, wdata1);
    if (we0) begin wa0.push_back(addr0); wd0.push_back(wdata0); cyc_we0 = cyc; end
    if (we1) begin wa1.push_back(addr1); wd1.push_back(wdata1); end
    if (core0 && !core0_q) cyc_core0 = cyc;
    core0_q = core0;
  end

  task automatic set_in(input int d, input logic v, input logic [7:0] b);
    if (d == 0) begin bv0 = v; bd0 = b; end
    else        begin bv1 = v; bd1 = b; end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input int gap);
    logic got;
    logic r;
    got = 1'b0;
    set_in(d, 1'b1, b);
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      r = (d == 0) ? rdy0 : rdy1;
      tick();
      got = r;
    end
    set_in(d, 1'b0, 8'h00);
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h on dut%0d got no byte_ready within 64 cycles", b, d);
    end
    repeat (gap) tick();
  endtask

  task automatic clear_logs();
    wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    clear_logs();
  endtask

  logic [7:0] img1 [10];

  initial begin
    reset = 1'b0;
    bv0 = 1'b0; bv1 = 1'b0; bd0 = 8'h00; bd1 = 8'h00;
    img1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    repeat (3) tick();
    reset = 1'b1;

    // Two-word image, back to back
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(0, img1[i], 0);
    repeat (4) tick();
    chk("t1_nwrites", 32'(wa0.size()), 32'd2);
    if (wa0.size() == 2) begin
      chk("t1_addr0", wa0[0], 32'h0000_0000);
      chk("t1_data0", wd0[0], 32'h0000_0013);
      chk("t1_addr1", wa0[1], 32'h0000_0004);
      chk("t1_data1", wd0[1], 32'h0010_0093);
    end
    chk("t1_done", 32'(done0), 32'd1);
    chk("t1_core", 32'(core0), 32'd1);
    chk("t1_core_after_we", 32'((cyc_core0 - cyc_we0) inside {[1:2]}), 32'd1);

    // Same image with 3-cycle gaps
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(0, img1[i], 3);
    repeat (4) tick();
    chk("t2_nwrites", 32'(wa0.size()), 32'd2);
    if (wa0.size() == 2) begin
      chk("t2_addr1", wa0[1], 32'h0000_0004);
      chk("t2_data1", wd0[1], 32'h0010_0093);
    end

    // Empty image
    do_reset();
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h00, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t3_done", 32'(done0), 32'd1);
    chk("t3_core", 32'(core0), 32'd1);
    chk("t3_nwrites", 32'(wa0.size()), 32'd0);

    // Oversized image (N=257), trailing bytes ignored
    do_reset();
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h01, 0);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'b1, 8'(8'hA0 + i));
      tick();
    end
    set_in(0, 1'b0, 8'h00);
    repeat (3) tick();
    chk("t4_error", 32'(err0), 32'd1);
    chk("t4_ready", 32'(rdy0), 32'd0);
    chk("t4_core", 32'(core0), 32'd0);
    chk("t4_nwrites", 32'(wa0.size()), 32'd0);

    // Reset mid-load, then a fresh one-word image
    do_reset();
    send_byte(0, 8'h03, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h11, 0); send_byte(0, 8'h22, 0);
    send_byte(0, 8'h33, 0); send_byte(0, 8'h44, 0);
    send_byte(0, 8'h55, 0); send_byte(0, 8'h66, 0);
    reset = 1'b0;
    tick();
    chk("t5_rst_we", 32'(we0), 32'd0);
    chk("t5_rst_addr", addr0, 32'h0000_0000);
    chk("t5_rst_wdata", wdata0, 32'h0000_0000);
    chk("t5_rst_ready", 32'(rdy0), 32'd0);
    chk("t5_rst_flags", {29'd0, core0, done0, err0}, 32'd0);
    tick();
    reset = 1'b1;
    chk("t5_nwrites", 32'(wa0.size()), 32'd1);
    if (wa0.size() == 1) chk("t5_data0", wd0[0], 32'h4433_2211);
    clear_logs();
    send_byte(0, 8'h01, 0); send_byte(0, 8'h00, 0);
    send_byte(0, 8'hEF, 0); send_byte(0, 8'hBE, 0);
    send_byte(0, 8'hAD, 0); send_byte(0, 8'hDE, 0);
    repeat (3) tick();
    chk("t5b_nwrites", 32'(wa0.size()), 32'd1);
    if (wa0.size() == 1) begin
      chk("t5b_addr", wa0[0], 32'h0000_0000);
      chk("t5b_data", wd0[0], 32'hDEAD_BEEF);
    end
    chk("t5b_done", 32'(done0), 32'd1);

    // Full-depth image at base 0x100
    do_reset();
    send_byte(1, 8'h00, 0);
    send_byte(1, 8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(1, 8'h3C, 0);
      send_byte(1, ~8'(i), 0);
      send_byte(1, 8'hA5, 0);
      send_byte(1, 8'(i), 0);
    end
    repeat (10) tick();
    chk("t6_nwrites", 32'(wa1.size()), 32'd256);
    if (wa1.size() == 256) begin
      chk("t6_first_addr", wa1[0], 32'h0000_0100);
      chk("t6_first_data", wd1[0], 32'h00A5_FF3C);
      chk("t6_last_addr", wa1[255], 32'h0000_04FC);
      chk("t6_last_data", wd1[255], 32'hFFA5_003C);
    end
    chk("t6_error", 32'(err1), 32'd0);
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_core", 32'(core1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Streams a program image into instruction memory after reset, and holds the single-cycle core in reset until the image is fully written.
- Sits between an external byte source (bench or debug link) and the instruction-memory write port.
- Drives the core's active-low reset.
- It is the writer side of the instruction memory the core fetches from.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- ADDR_W, 32, width of imem_addr.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  image byte.
- byte_ready  output  1  loader accepts byte this cycle; transfer occurs when byte_valid & byte_ready.
- imem_we  output  1  one-cycle write strobe to instruction memory.
- imem_addr  output  ADDR_W  byte address of the write; always word-aligned.
- imem_wdata  output  32  instruction word.
- core_reset  output  1  active-low reset to the core; 0 while loading.
- load_done  output  1  image loaded; sticky until reset.
- load_error  output  1  length exceeds DEPTH; sticky until reset.

Behaviour:
- Reset (reset==0 at a clk edge): state=S_LEN0; byte/word counters=0; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; core_reset=0; load_done=0; load_error=0; byte_ready=0.
  - byte_ready becomes 1 on the first edge with reset==1.
- Image format: 2-byte little-endian word count N, followed by 4*N bytes, little-endian per word (first byte -> wdata[7:0]).
- States:
  - S_LEN0: accept byte -> len[7:0]; go to S_LEN1.
  - S_LEN1: accept byte -> len[15:8]; evaluate the full length:
    - N==0 -> S_DONE.
    - N>DEPTH -> S_ERR.
    - otherwise -> S_DATA.
  - S_DATA: shift accepted bytes into an assembly register; byte index 0..3 wraps.
    - On acceptance of byte index 3: on the next edge, imem_we=1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = BASE_ADDR + 4*word_idx. Then word_idx increments.
    - After the write for word N-1 -> S_DONE.
  - S_DONE: byte_ready=0; load_done=1; core_reset=1, registered one cycle after entering S_DONE. This guarantees core_reset rises at least one cycle after the last imem_we.
  - S_ERR: byte_ready=0; load_error=1; core_reset stays 0. Only reset exits S_ERR.
- byte_ready is 1 in S_LEN0, S_LEN1 and S_DATA, independent of byte_valid.
- Bytes presented while byte_ready==0 are ignored and are not counted.
- Gaps of any length (byte_valid==0) are allowed between bytes; no timeout.
- Maximum throughput: one byte per cycle, i.e. one imem_we every 4 cycles.
- A write pulse and acceptance of the next word's byte 0 may occur in the same cycle.
- Address arithmetic is modulo 2^ADDR_W. word_idx width is clog2(DEPTH+1).
- N==DEPTH is legal; the last write lands at BASE_ADDR+4*(DEPTH-1).
- Reset asserted mid-load:
  - The partial word is discarded and no write is issued.
  - core_reset returns to 0 and all flags clear.
  - Loading restarts at S_LEN0; memory contents already written are not cleared.

Decomposition:
- Shared package (boot_pkg):
  - enum loader_state_t {S_LEN0, S_LEN1, S_DATA, S_DONE, S_ERR}.
  - Constant LEN_BYTES=2, BYTES_PER_WORD=4.
- One sub-module, byte_to_word_packer: accepts a byte strobe, emits a 32-bit word plus a one-cycle word_valid on every 4th byte, and has a clear input driven by reset and state.
- The top-level FSM owns length, address and the core_reset sequencing.

Test Plan:
- Reset, then bytes 02 00 13 00 00 00 93 00 10 00, one per cycle -> writes 0x00000013 at 0x0 and 0x00100093 at 0x4. load_done=1. core_reset=1 one cycle after the second imem_we.
- Same image, with byte_valid deasserted for 3 cycles between every byte -> identical writes and addresses. Exactly 2 imem_we pulses.
- Length bytes 00 00 -> no imem_we. load_done=1 and core_reset=1 within 2 cycles of the second length byte.
- DEPTH=256, length 01 01 (N=257) -> load_error=1, byte_ready=0, core_reset stays 0, no writes. Further bytes are ignored.
- N=3; assert reset after 6 data bytes -> no write for the partial second word. All outputs return to reset values. A fresh image (N=1, bytes EF BE AD DE) writes 0xDEADBEEF at 0x0.
- BASE_ADDR=32'h100, N=256 streamed back-to-back -> 256 writes, the last at 0x4FC. load_error=0. No imem_we after the 256th write.
